// File: rtl/reg_read_arbiter_if.sv
// rtl/reg_read_arbiter_if.sv - requester/register-bank bundle for the shared read port
interface reg_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    logic                      Stall;
    logic [NUM_REQ-1:0]        Req;
    logic [NUM_REQ*ADDR_W-1:0] Addr;
    logic [NUM_REQ-1:0]        Gnt;
    logic [ADDR_W-1:0]         MuxSel;
    logic [DATA_W-1:0]         MuxData;
    logic                      WrEn;
    logic [ADDR_W-1:0]         WrAddr;
    logic [DATA_W-1:0]         WrData;
    logic [DATA_W-1:0]         RdData;
    logic [NUM_REQ-1:0]        RdValid;
    logic                      Busy;

    // master is the requester/bank side, slave is the arbiter itself
    modport master (
        output Stall, Req, Addr, MuxData, WrEn, WrAddr, WrData,
        input  Gnt, MuxSel, RdData, RdValid, Busy
    );

    modport slave (
        input  Stall, Req, Addr, MuxData, WrEn, WrAddr, WrData,
        output Gnt, MuxSel, RdData, RdValid, Busy
    );
endinterface

// File: rtl/reg_read_arbiter.sv
// rtl/reg_read_arbiter.sv - round-robin arbiter sharing one register-bank read port
module reg_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic            Clk,
    input  logic            Reset_n,
    reg_read_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   win;
    logic               grant;
    int                 idx;
    logic [NUM_REQ-1:0] gnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  rd_value;
    logic [DATA_W-1:0]  rd_data;
    logic [NUM_REQ-1:0] rd_valid;

    // Scan from the highest offset down so the last hit is the nearest to ptr.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        idx   = 0;
        if (!bus.Stall) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (bus.Req[idx]) begin
                    grant = 1'b1;
                    win   = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt      = '0;
        sel_addr = '0;
        if (grant) begin
            gnt      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            sel_addr = bus.Addr[int'(win)*ADDR_W +: ADDR_W];
        end
    end

    assign ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

    // Register 0 wins over a same-cycle write to it; otherwise a matching write bypasses the bank.
    always_comb begin
        if (sel_addr == '0) begin
            rd_value = '0;
        end else if (bus.WrEn && (bus.WrAddr == sel_addr)) begin
            rd_value = bus.WrData;
        end else begin
            rd_value = bus.MuxData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr      <= '0;
            rd_data  <= '0;
            rd_valid <= '0;
        end else if (grant) begin
            ptr      <= ptr_next;
            rd_data  <= rd_value;
            rd_valid <= gnt;
        end else begin
            rd_valid <= '0;
        end
    end

    assign bus.Gnt     = gnt;
    assign bus.MuxSel  = sel_addr;
    assign bus.RdData  = rd_data;
    assign bus.RdValid = rd_valid;
    assign bus.Busy    = (|bus.Req) && (bus.Stall || ($countones(bus.Req) > 1));
endmodule
